dac_spi_tx: RTL and testbench

Output end of the FIR sample path. Generates the periodic sample-request strobe that drives the filter's `ready_i`, accepts each filtered sample on `valid_i`, converts it to offset binary and shifts it to an external SPI DAC as one framed word. A one-entry holding register decouples filter output timing from SPI frame timing.

---
 rtl/dac_spi_pkg.sv | 18 +
 rtl/dac_spi_tx_if.sv | 11 +
 rtl/dac_spi_tx_strobe.sv | 26 ++
 rtl/dac_spi_tx.sv | 135 +++++++++++++
 tb/tb_dac_spi_tx.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_spi_pkg.sv
// rtl/dac_spi_pkg.sv - shared types, constants and helpers for the DAC SPI transmitter
package dac_spi_pkg;

    localparam int CMD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TAIL,
        GAP
    } state_t;

    // Offset binary: flip only the sign bit of a dw-bit two's complement value
    function automatic logic [63:0] to_offset_binary(input logic [63:0] sample, input int dw);
        return sample ^ (64'd1 << (dw - 1));
    endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// rtl/dac_spi_tx_if.sv - sample handshake between the FIR filter and the DAC transmitter
interface dac_spi_tx_if #(
    parameter int DW = 16
);
    logic          req_o;
    logic [DW-1:0] data_i;
    logic          valid_i;

    modport master (output data_i, output valid_i, input req_o);
    modport slave  (input data_i, input valid_i, output req_o);
endinterface

// File: rtl/dac_spi_tx_strobe.sv
// rtl/dac_spi_tx_strobe.sv - free-running period counter with a one-cycle pulse on its last count
module sample_strobe #(
    parameter int PERIOD = 2083
) (
    input  logic clock,
    input  logic reset,
    output logic pulse_o
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign pulse_o = (r_cnt == LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - sample request, holding register and framed SPI shift-out to a DAC
// Optional load strobe output ldac_n_o when DAC_SPI_TX_LDAC_EN is defined.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int                DW         = 16,
    parameter int                SCLK_DIV   = 4,
    parameter int                SAMPLE_DIV = 2083,
    parameter logic [CMD_W-1:0]  CMD        = 8'h30
) (
    input  logic         clock,
    input  logic         reset,
    dac_spi_tx_if.slave  smp,
    output logic         sclk_o,
    output logic         mosi_o,
    output logic         cs_n_o,
    output logic         busy_o,
    output logic         overrun_o
`ifdef DAC_SPI_TX_LDAC_EN
    ,
    output logic         ldac_n_o
`endif
);
    localparam int FW     = CMD_W + DW;
    localparam int HALVES = 2 * FW;
    localparam int DVW    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int HW     = $clog2(HALVES);
    localparam logic [DVW-1:0] DIV_LAST  = DVW'(SCLK_DIV - 1);
    localparam logic [HW-1:0]  HALF_LAST = HW'(HALVES - 1);

    if (SCLK_DIV < 1) begin : g_bad_sclk_div
        $error("dac_spi_tx: SCLK_DIV must be at least 1");
    end
    if (SAMPLE_DIV < (HALVES + 2) * SCLK_DIV + 1) begin : g_bad_sample_div
        $error("dac_spi_tx: SAMPLE_DIV shorter than one frame, overruns guaranteed");
    end

    state_t          r_state;
    state_t          w_next;
    logic            w_load;
    logic [DVW-1:0]  r_div;
    logic [HW-1:0]   r_half;
    logic [FW-1:0]   r_shift;
    logic [DW-1:0]   r_hold;
    logic            r_full;
    logic            r_overrun;
    logic            w_div_end;
    logic            w_half_end;

    sample_strobe #(.PERIOD(SAMPLE_DIV)) u_strobe (
        .clock   (clock),
        .reset   (reset),
        .pulse_o (smp.req_o)
    );

    assign w_div_end  = (r_div == DIV_LAST);
    assign w_half_end = (r_half == HALF_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_full) begin
                    w_next = SHIFT;
                    w_load = 1'b1;
                end
            end
            SHIFT:   if (w_div_end && w_half_end) w_next = TAIL;
            TAIL:    if (w_div_end) w_next = GAP;
            GAP:     if (w_div_end) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Even half-periods are SCLK low; the next bit is presented as each high half ends
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div   <= '0;
            r_half  <= '0;
            r_shift <= '0;
        end else if (w_load) begin
            r_div   <= '0;
            r_half  <= '0;
            r_shift <= {CMD, DW'(to_offset_binary(64'(r_hold), DW))};
        end else if (r_state != IDLE) begin
            if (w_div_end) begin
                r_div <= '0;
                if (r_state == SHIFT) begin
                    r_half <= r_half + 1'b1;
                    if (r_half[0] && !w_half_end) begin
                        r_shift <= {r_shift[FW-2:0], 1'b0};
                    end
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    // A new sample arriving on the consume cycle refills the register without loss
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hold    <= '0;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
        end else if (smp.valid_i) begin
            r_hold <= smp.data_i;
            r_full <= 1'b1;
            if (r_full && !w_load) begin
                r_overrun <= 1'b1;
            end
        end else if (w_load) begin
            r_full <= 1'b0;
        end
    end

    assign sclk_o    = (r_state == SHIFT) && r_half[0];
    assign mosi_o    = r_shift[FW-1];
    assign cs_n_o    = (r_state == IDLE) || (r_state == GAP);
    assign busy_o    = (r_state != IDLE);
    assign overrun_o = r_overrun;
`ifdef DAC_SPI_TX_LDAC_EN
    assign ldac_n_o  = (r_state != GAP);
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb/tb_dac_spi_tx.sv - scoreboard bench for dac_spi_tx with an SPI sampler monitor
module tb_dac_spi_tx;
    localparam int DW         = 16;
    localparam int SCLK_DIV   = 2;
    localparam int SAMPLE_DIV = 120;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sclk, mosi, cs_n, busy, overrun;
`ifdef DAC_SPI_TX_LDAC_EN
    logic ldac_n;
`endif

    always #5 clock = ~clock;

    dac_spi_tx_if #(.DW(DW)) smp ();

    dac_spi_tx #(
        .DW         (DW),
        .SCLK_DIV   (SCLK_DIV),
        .SAMPLE_DIV (SAMPLE_DIV),
        .CMD        (8'h30)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .smp       (smp),
        .sclk_o    (sclk),
        .mosi_o    (mosi),
        .cs_n_o    (cs_n),
        .busy_o    (busy),
        .overrun_o (overrun)
`ifdef DAC_SPI_TX_LDAC_EN
        ,
        .ldac_n_o  (ldac_n)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // SPI sampler and frame scoreboard, sampling on the falling system clock edge
    logic        prev_sclk = 1'b0;
    logic        prev_cs   = 1'b1;
    logic        prev_busy = 1'b0;
    logic [23:0] sh        = '0;
    int          nbits     = 0;
    int          cs_low    = 0;
    int          busy_len  = 0;
    int          rst_sclk  = 0;
    int          ldac_len  = 0;

    always @(negedge clock) begin
        if (reset) begin
            if (sclk) rst_sclk++;
            sh = '0; nbits = 0; cs_low = 0; busy_len = 0; ldac_len = 0;
            prev_sclk = 1'b0; prev_cs = 1'b1; prev_busy = 1'b0;
        end else begin
            if (!cs_n) cs_low++;
            if (busy) busy_len++;
            if (!cs_n && sclk && !prev_sclk) begin
                sh = {sh[22:0], mosi};
                nbits++;
            end
            if (cs_n && !prev_cs) begin
                check("frame_bits", nbits, 24);
                check("cs_low_cycles", cs_low, 98);
                if (exp_q.size() == 0) check("unexpected_frame", sh, 32'hFFFF_FFFF);
                else                   check("frame_word", sh, exp_q.pop_front());
`ifdef DAC_SPI_TX_LDAC_EN
                check("ldac_at_cs_rise", ldac_n, 0);
`endif
                nbits = 0; cs_low = 0;
            end
            if (!busy && prev_busy) begin
                check("busy_cycles", busy_len, 100);
                busy_len = 0;
            end
`ifdef DAC_SPI_TX_LDAC_EN
            if (!ldac_n) ldac_len++;
            else if (ldac_len != 0) begin
                check("ldac_cycles", ldac_len, 2);
                ldac_len = 0;
            end
`endif
            prev_sclk = sclk; prev_cs = cs_n; prev_busy = busy;
        end
    end

    task automatic send(input logic [15:0] d, input logic [23:0] exp);
        @(negedge clock);
        smp.data_i  = d;
        smp.valid_i = 1'b1;
        exp_q.push_back(exp);
        @(negedge clock);
        smp.valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_drain_in_time"}, (n < 2000), 1);
    endtask

    logic [15:0] vin  [4] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h1234};
    logic [23:0] vexp [4] = '{24'h30FFFF, 24'h300000, 24'h308000, 24'h309234};

    initial begin
        int n;
        smp.valid_i = 1'b0;
        smp.data_i  = '0;

        // Reset state and request cadence
        repeat (10) @(negedge clock);
        check("rst_req", smp.req_o, 0);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        n = 0;
        // Filter samples req on the edge following this negedge, i.e. edge SAMPLE_DIV
        while (!smp.req_o && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("first_req_delay", n, SAMPLE_DIV - 1);
        for (int p = 0; p < 2; p++) begin
            @(negedge clock);
            check("req_width", smp.req_o, 0);
            n = 1;
            while (!smp.req_o && n < 500) begin
                @(negedge clock);
                n++;
            end
            check("req_period", n, SAMPLE_DIV);
        end

        // Single sample with latency
        @(negedge clock);
        smp.data_i  = vin[0];
        smp.valid_i = 1'b1;
        exp_q.push_back(vexp[0]);
        @(posedge clock);
        @(negedge clock);
        smp.valid_i = 1'b0;
        check("lat_cs_n_edge_n", cs_n, 1);
        check("lat_busy_edge_n", busy, 0);
        @(posedge clock);
        #1;
        check("lat_cs_n_edge_n1", cs_n, 0);
        check("lat_busy_edge_n1", busy, 1);
        check("lat_mosi_msb", mosi, 0);
        wait_drain("single");
        check("single_overrun", overrun, 0);

        for (int i = 1; i < 4; i++) begin
            send(vin[i], vexp[i]);
            wait_drain("value");
        end
        check("values_overrun", overrun, 0);

        // Burst: A, B next cycle, C during A's frame; B is overwritten
        @(negedge clock);
        smp.data_i = 16'h1111; smp.valid_i = 1'b1;
        exp_q.push_back(24'h309111);
        @(negedge clock);
        smp.data_i = 16'h2222;
        @(negedge clock);
        smp.valid_i = 1'b0;
        check("burst_b_no_overrun", overrun, 0);
        repeat (20) @(negedge clock);
        check("burst_pre_c_overrun", overrun, 0);
        smp.data_i = 16'h4321; smp.valid_i = 1'b1;
        exp_q.push_back(24'h30C321);
        @(negedge clock);
        smp.valid_i = 1'b0;
        check("burst_c_overrun", overrun, 1);
        wait_drain("burst");
        check("burst_overrun_sticky", overrun, 1);

        // Reset during bit 10 of a frame with a sample also waiting in the holding register
        @(negedge clock);
        smp.data_i = 16'h5555; smp.valid_i = 1'b1;
        @(negedge clock);
        smp.valid_i = 1'b0;
        repeat (4) @(negedge clock);
        smp.data_i = 16'h6666; smp.valid_i = 1'b1;
        @(negedge clock);
        smp.valid_i = 1'b0;
        n = 0;
        while (nbits < 10 && n < 500) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("abort_reached_bit10", nbits, 10);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("abort_cs_n", cs_n, 1);
        check("abort_sclk", sclk, 0);
        check("abort_busy", busy, 0);
        repeat (5) @(negedge clock);
        check("abort_overrun_cleared", overrun, 0);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        check("abort_no_restart", busy, 0);
        check("abort_sclk_quiet", rst_sclk + nbits, 0);
        send(16'hABCD, 24'h302BCD);
        wait_drain("post_reset");
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
